// File: rtl/coh_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared snoopy coherence bus.
// One transaction is in flight at a time; ownership ends on bus_done or timeout.
module coh_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 20,
    parameter int TIMEOUT = 64,
    localparam int SRC_W  = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [2*NUM_REQ-1:0]      req_cmd,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      bus_valid,
    output logic [1:0]                bus_cmd,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [SRC_W-1:0]          bus_src,
    input  logic                      bus_done,
    output logic                      bus_err,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic                valid_q;
    logic [1:0]          cmd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [SRC_W-1:0]    src_q;
    logic                err_q;
    logic                busy_q;
    logic [SRC_W-1:0]    rr_ptr_q;
    logic [7:0]          cnt_q;

    logic                found_s;
    logic [SRC_W-1:0]    win_s;
    logic [SRC_W:0]      sum_s;
    logic [NUM_REQ-1:0]  gnt_s;
    logic [1:0]          win_cmd_s;
    logic [ADDR_W-1:0]   win_addr_s;
    logic [SRC_W-1:0]    rr_ptr_d;

    // Winner search starts at rr_ptr and wraps, so the last owner has lowest priority.
    always_comb begin
        found_s    = 1'b0;
        win_s      = '0;
        sum_s      = '0;
        gnt_s      = '0;
        win_cmd_s  = 2'b00;
        win_addr_s = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            sum_s = {1'b0, rr_ptr_q} + (SRC_W+1)'(j);
            if (sum_s >= (SRC_W+1)'(NUM_REQ)) begin
                sum_s = sum_s - (SRC_W+1)'(NUM_REQ);
            end else begin
                sum_s = sum_s;
            end
            if (!found_s && req[sum_s[SRC_W-1:0]]) begin
                found_s = 1'b1;
                win_s   = sum_s[SRC_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_s == SRC_W'(i)) begin
                gnt_s[i]   = 1'b1;
                win_cmd_s  = req_cmd[2*i +: 2];
                win_addr_s = req_addr[ADDR_W*i +: ADDR_W];
            end else begin
                gnt_s[i]   = 1'b0;
            end
        end
        if (src_q == SRC_W'(NUM_REQ-1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = src_q + 1'b1;
        end
    end

    // Bus sequencing FSM; every output comes straight from a register here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            cmd_q    <= 2'b00;
            addr_q   <= '0;
            src_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            rr_ptr_q <= '0;
            cnt_q    <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    err_q <= 1'b0;
                    if (found_s) begin
                        grant_q <= gnt_s;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        cmd_q   <= win_cmd_s;
                        addr_q  <= win_addr_s;
                        src_q   <= win_s;
                        state_q <= GRANT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GRANT: begin
                    valid_q <= 1'b0;
                    cnt_q   <= 8'd0;
                    if (bus_done) begin
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                    end else begin
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    // A completion in the timeout cycle still counts as success.
                    if (bus_done) begin
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                    end else if (cnt_q == 8'(TIMEOUT-1)) begin
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                        err_q    <= 1'b1;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q    <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign bus_valid = valid_q;
    assign bus_cmd   = cmd_q;
    assign bus_addr  = addr_q;
    assign bus_src   = src_q;
    assign bus_err   = err_q;
    assign busy      = busy_q;

endmodule
